// File: rtl/spi_slave_fifo.sv
// SPI slave endpoint: deserialises 8-bit LSB-first frames from mosi into an RX FIFO
// and serialises a locally loaded TX byte onto miso. Back-to-back frames are supported
// while cs_n stays low.
module spi_slave_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic          sclk,
    input  logic          reset,
    input  logic          cs_n,
    input  logic          mosi,
    output logic          miso,
    input  logic [7:0]    tx_data,
    input  logic          tx_load,
    output logic          tx_pending,
    output logic [7:0]    rx_data,
    output logic          rx_valid,
    input  logic          rx_pop,
    output logic [AW:0]   rx_count,
    output logic          rx_overflow,
    input  logic          ovf_clr,
    output logic          frame_done,
    output logic          frame_err
);

    localparam logic [0:0] StIdle  = 1'b0;
    localparam logic [0:0] StShift = 1'b1;
    localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);

    logic [0:0]    state_q, state_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic [7:0]    tx_shift_q, tx_shift_d;
    logic [7:0]    tx_buf_q, tx_buf_d;
    logic          tx_pending_q, tx_pending_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic          ovf_q, ovf_d;
    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q, count_d;

    logic [7:0]    push_byte;
    logic          push, pop, wr, full, empty;

    assign push_byte = {mosi, rx_shift_q[7:1]};
    assign full      = (count_q == FullCount);
    assign empty     = (count_q == '0);
    assign pop       = rx_pop && !empty;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign wr        = push && (!full || pop);

    // Link FSM, shifters and TX buffer next-state.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        rx_shift_d   = rx_shift_q;
        tx_shift_d   = tx_shift_q;
        tx_buf_d     = tx_buf_q;
        tx_pending_d = tx_pending_q;
        done_d       = 1'b0;
        err_d        = 1'b0;
        push         = 1'b0;
        if (!cs_n) begin
            state_d    = StShift;
            rx_shift_d = push_byte;
            tx_shift_d = {1'b0, tx_shift_q[7:1]};
            bit_cnt_d  = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
                push         = 1'b1;
                done_d       = 1'b1;
                // Underrun returns zeros on the next frame.
                tx_shift_d   = tx_pending_q ? tx_buf_q : 8'h00;
                tx_pending_d = 1'b0;
            end
        end else begin
            state_d   = StIdle;
            bit_cnt_d = 3'd0;
            if (state_q == StShift && bit_cnt_q != 3'd0) begin
                err_d      = 1'b1;
                rx_shift_d = 8'h00;
            end
            // Preload while idle so miso carries bit 0 before the first edge.
            if (state_q == StIdle && tx_pending_q) begin
                tx_shift_d   = tx_buf_q;
                tx_pending_d = 1'b0;
            end
        end
        // A fresh load survives a same-cycle reload, which used the old buffer.
        if (tx_load) begin
            tx_buf_d     = tx_data;
            tx_pending_d = 1'b1;
        end
    end

    // FIFO occupancy and sticky overflow next-state.
    always_comb begin
        count_d = count_q + {{AW{1'b0}}, wr} - {{AW{1'b0}}, pop};
        ovf_d   = ovf_q;
        if (ovf_clr) ovf_d = 1'b0;
        if (push && full && !pop) ovf_d = 1'b1;
    end

    // Link-side state registers.
    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            bit_cnt_q    <= 3'd0;
            rx_shift_q   <= 8'h00;
            tx_shift_q   <= 8'h00;
            tx_buf_q     <= 8'h00;
            tx_pending_q <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_shift_q   <= rx_shift_d;
            tx_shift_q   <= tx_shift_d;
            tx_buf_q     <= tx_buf_d;
            tx_pending_q <= tx_pending_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

    // RX FIFO storage, pointers and flags.
    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= 8'h00;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr) begin
                mem_q[wr_ptr_q] <= push_byte;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign miso        = !cs_n && tx_shift_q[0];
    assign tx_pending  = tx_pending_q;
    assign rx_data     = empty ? 8'h00 : mem_q[rd_ptr_q];
    assign rx_valid    = !empty;
    assign rx_count    = count_q;
    assign rx_overflow = ovf_q;
    assign frame_done  = done_q;
    assign frame_err   = err_q;

endmodule
